vr_commit_walker: RTL and testbench



---
 rtl/vr_commit_walker.sv | 152 +++++++++++++++
 tb/tb_vr_commit_walker.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vr_commit_walker.sv
// VR COMMIT engine: validates a COMMIT against VR state, then read-modify-writes each newly
// committed log entry's flag and writes back last-commit. VR_COMMIT_WALKER_STATS_EN adds counters.
module vr_commit_walker #(
  parameter int NOC_DATA_W     = 512,
  parameter int OP_NUM_W       = 64,
  parameter int LOG_DEPTH_LOG2 = 10,
  parameter int COMMIT_BIT     = 0,
  parameter int MAX_WALK       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      msg_val,
  input  logic [OP_NUM_W-1:0]       msg_view,
  input  logic [OP_NUM_W-1:0]       msg_commit_num,
  output logic                      msg_rdy,
  input  logic [OP_NUM_W-1:0]       state_view,
  input  logic [OP_NUM_W-1:0]       state_last_commit,
  input  logic [OP_NUM_W-1:0]       state_op_num,
  output logic                      state_wr_val,
  output logic [OP_NUM_W-1:0]       state_wr_last_commit,
  input  logic                      state_wr_rdy,
  output logic                      log_rd_req_val,
  output logic [LOG_DEPTH_LOG2-1:0] log_rd_req_addr,
  input  logic                      log_rd_req_rdy,
  input  logic                      log_rd_resp_val,
  input  logic [NOC_DATA_W-1:0]     log_rd_resp_data,
  output logic                      log_rd_resp_rdy,
  output logic                      log_wr_val,
  output logic [LOG_DEPTH_LOG2-1:0] log_wr_addr,
  output logic [NOC_DATA_W-1:0]     log_wr_data,
  input  logic                      log_wr_rdy,
  output logic                      busy
`ifdef VR_COMMIT_WALKER_STATS_EN
  ,
  output logic [31:0]               stat_entries_committed,
  output logic [31:0]               stat_msgs_dropped
`endif
);

  typedef enum logic [2:0] {IDLE, CHECK, RD_REQ, RD_RESP, WR, STATE_WR} state_e;

  state_e                state_q, state_d;
  logic [OP_NUM_W-1:0]   view_q, view_d;
  logic [OP_NUM_W-1:0]   commit_num_q, commit_num_d;
  logic [OP_NUM_W-1:0]   target_q, target_d;
  logic [OP_NUM_W-1:0]   cur_q, cur_d;
  logic [NOC_DATA_W-1:0] data_q, data_d;
  logic [OP_NUM_W-1:0]   walk_lim_c, tgt_c;
  logic                  drop_c;

  always_comb begin
    state_d      = state_q;
    view_d       = view_q;
    commit_num_d = commit_num_q;
    target_d     = target_q;
    cur_d        = cur_q;
    data_d       = data_q;
    // Walk target is the smallest of leader commit, local op number and the per-message cap.
    walk_lim_c   = state_last_commit + OP_NUM_W'(MAX_WALK);
    tgt_c        = commit_num_q;
    if (state_op_num < tgt_c) tgt_c = state_op_num;
    if (walk_lim_c < tgt_c)   tgt_c = walk_lim_c;
    drop_c       = (view_q != state_view) || (tgt_c <= state_last_commit);
    case (state_q)
      IDLE: if (msg_val) begin
        view_d       = msg_view;
        commit_num_d = msg_commit_num;
        state_d      = CHECK;
      end
      CHECK: begin
        target_d = tgt_c;
        if (drop_c) begin
          state_d = IDLE;
        end else begin
          cur_d   = state_last_commit + OP_NUM_W'(1);
          state_d = RD_REQ;
        end
      end
      RD_REQ: if (log_rd_req_rdy) state_d = RD_RESP;
      RD_RESP: if (log_rd_resp_val) begin
        data_d             = log_rd_resp_data;
        data_d[COMMIT_BIT] = 1'b1;
        state_d            = WR;
      end
      WR: if (log_wr_rdy) begin
        if (cur_q == target_q) begin
          state_d = STATE_WR;
        end else begin
          cur_d   = cur_q + OP_NUM_W'(1);
          state_d = RD_REQ;
        end
      end
      STATE_WR: if (state_wr_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      view_q       <= '0;
      commit_num_q <= '0;
      target_q     <= '0;
      cur_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      view_q       <= view_d;
      commit_num_q <= commit_num_d;
      target_q     <= target_d;
      cur_q        <= cur_d;
      data_q       <= data_d;
    end
  end

  assign msg_rdy              = (state_q == IDLE);
  assign busy                 = (state_q != IDLE);
  assign log_rd_req_val       = (state_q == RD_REQ);
  assign log_rd_req_addr      = cur_q[LOG_DEPTH_LOG2-1:0];
  assign log_rd_resp_rdy      = (state_q == RD_RESP);
  assign log_wr_val           = (state_q == WR);
  assign log_wr_addr          = cur_q[LOG_DEPTH_LOG2-1:0];
  assign log_wr_data          = data_q;
  assign state_wr_val         = (state_q == STATE_WR);
  assign state_wr_last_commit = target_q;

`ifdef VR_COMMIT_WALKER_STATS_EN
  logic [31:0] stat_ent_q, stat_ent_d;
  logic [31:0] stat_drop_q, stat_drop_d;

  always_comb begin
    stat_ent_d  = stat_ent_q;
    stat_drop_d = stat_drop_q;
    if (state_q == WR && log_wr_rdy) stat_ent_d  = stat_ent_q + 32'd1;
    if (state_q == CHECK && drop_c)  stat_drop_d = stat_drop_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ent_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_ent_q  <= stat_ent_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_entries_committed = stat_ent_q;
  assign stat_msgs_dropped      = stat_drop_q;
`endif

endmodule

// File: tb/tb_vr_commit_walker.sv
// Self-checking bench for vr_commit_walker: directed table, randomized messages against a
// behavioural commit model, stall stability and mid-walk reset.
module tb_vr_commit_walker;
  localparam int DW = 64, OW = 32, AW = 5, CB = 5, MW = 16, DEPTH = 1 << AW;

  logic clk, rst_n;
  logic msg_val, msg_rdy;
  logic [OW-1:0] msg_view, msg_commit_num, state_view, state_last_commit, state_op_num;
  logic state_wr_val, state_wr_rdy;
  logic [OW-1:0] state_wr_last_commit;
  logic log_rd_req_val, log_rd_req_rdy, log_rd_resp_val, log_rd_resp_rdy;
  logic [AW-1:0] log_rd_req_addr, log_wr_addr;
  logic [DW-1:0] log_rd_resp_data, log_wr_data;
  logic log_wr_val, log_wr_rdy, busy;
`ifdef VR_COMMIT_WALKER_STATS_EN
  logic [31:0] stat_entries_committed, stat_msgs_dropped;
`endif

  vr_commit_walker #(.NOC_DATA_W(DW), .OP_NUM_W(OW), .LOG_DEPTH_LOG2(AW),
                     .COMMIT_BIT(CB), .MAX_WALK(MW)) dut (
    .clk(clk), .rst_n(rst_n), .msg_val(msg_val), .msg_view(msg_view),
    .msg_commit_num(msg_commit_num), .msg_rdy(msg_rdy), .state_view(state_view),
    .state_last_commit(state_last_commit), .state_op_num(state_op_num),
    .state_wr_val(state_wr_val), .state_wr_last_commit(state_wr_last_commit),
    .state_wr_rdy(state_wr_rdy), .log_rd_req_val(log_rd_req_val),
    .log_rd_req_addr(log_rd_req_addr), .log_rd_req_rdy(log_rd_req_rdy),
    .log_rd_resp_val(log_rd_resp_val), .log_rd_resp_data(log_rd_resp_data),
    .log_rd_resp_rdy(log_rd_resp_rdy), .log_wr_val(log_wr_val), .log_wr_addr(log_wr_addr),
    .log_wr_data(log_wr_data), .log_wr_rdy(log_wr_rdy), .busy(busy)
`ifdef VR_COMMIT_WALKER_STATS_EN
    , .stat_entries_committed(stat_entries_committed), .stat_msgs_dropped(stat_msgs_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] snap [DEPTH];
  int            rd_pend[$];
  wr_t           wr_log[$];
  logic [OW-1:0] st_log[$];
  bit            rand_rdy, stall_wr, resp_done;
  int            busy_cyc;
  int            checks, failures;
  int            exp_ent, exp_drop;
  logic [DW-1:0] cmask;

  // Memory / state-port responder; decides inputs for the next edge on each falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend.delete();
      log_rd_resp_val = 1'b0;
      resp_done       = 1'b0;
    end else begin
      log_rd_req_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      log_wr_rdy     = stall_wr ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      state_wr_rdy   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy) busy_cyc++;
      if (resp_done) begin
        log_rd_resp_val = 1'b0;
        resp_done       = 1'b0;
      end
      if (!log_rd_resp_val && rd_pend.size() > 0 && (!rand_rdy || $urandom_range(0, 1) == 1)) begin
        log_rd_resp_val  = 1'b1;
        log_rd_resp_data = mem[rd_pend[0]];
      end
      if (log_rd_resp_val && log_rd_resp_rdy) begin
        void'(rd_pend.pop_front());
        resp_done = 1'b1;
      end
      if (log_rd_req_val && log_rd_req_rdy) rd_pend.push_back(int'(log_rd_req_addr));
      if (log_wr_val && log_wr_rdy) begin
        wr_log.push_back('{addr: int'(log_wr_addr), data: log_wr_data});
        mem[log_wr_addr] = log_wr_data;
      end
      if (state_wr_val && state_wr_rdy) st_log.push_back(state_wr_last_commit);
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    msg_val = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ent  = 0;
    exp_drop = 0;
  endtask

  // Issues one COMMIT and waits (bounded) for the engine to return to idle.
  task automatic do_msg(input logic [OW-1:0] sv, slc, sop, mv, mc, input bit scramble,
                        output bit ok);
    wr_log.delete();
    st_log.delete();
    snap = mem;
    state_view = sv; state_last_commit = slc; state_op_num = sop;
    @(negedge clk);
    busy_cyc = 0;
    msg_view = mv; msg_commit_num = mc; msg_val = 1'b1;
    @(negedge clk);
    msg_val = 1'b0;
    @(negedge clk);
    if (scramble) begin
      state_view = $urandom; state_last_commit = $urandom; state_op_num = $urandom;
    end
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    msg_val = 1'b0;
    #1;
    checks++;
    if (msg_rdy !== 1'b1 || busy !== 1'b0 || log_rd_req_val !== 1'b0 || log_wr_val !== 1'b0 ||
        state_wr_val !== 1'b0 || log_rd_resp_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b busy=%b rd=%b wr=%b st=%b resp_rdy=%b want 1,0,0,0,0,0",
               msg_rdy, busy, log_rd_req_val, log_wr_val, state_wr_val, log_rd_resp_rdy);
    end
    checks++;
    if (state_wr_last_commit !== '0 || log_wr_data !== '0 || log_wr_addr !== '0) begin
      failures++;
      $display("FAIL reset_regs got lc=%0h data=%0h addr=%0h want 0", state_wr_last_commit,
               log_wr_data, log_wr_addr);
    end
`ifdef VR_COMMIT_WALKER_STATS_EN
    checks++;
    if (stat_entries_committed !== 0 || stat_msgs_dropped !== 0) begin
      failures++;
      $display("FAIL reset_stats got %0d/%0d want 0/0", stat_entries_committed, stat_msgs_dropped);
    end
`endif
    apply_reset();
  endtask

  // Directed table: {state view, last_commit, op_num, msg view, msg commit, expected target or -1}.
  task automatic test_directed();
    int tbl[6][6] = '{'{3, 5, 9, 3, 8, 8}, '{3, 5, 9, 2, 8, -1}, '{1, 10, 12, 1, 20, 12},
                      '{1, 0, 40, 1, 40, 16}, '{2, 30, 40, 2, 33, 33}, '{4, 5, 9, 4, 5, -1}};
    bit ok;
    int n, lc;
    rand_rdy = 1'b0;
    foreach (tbl[c]) begin
      lc = tbl[c][1];
      do_msg(OW'(tbl[c][0]), OW'(lc), OW'(tbl[c][2]), OW'(tbl[c][3]), OW'(tbl[c][4]), 1'b0, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL dir%0d_timeout engine still busy", c);
        apply_reset();
        continue;
      end
      n = (tbl[c][5] < 0) ? 0 : tbl[c][5] - lc;
      checks++;
      if (wr_log.size() != n) begin
        failures++;
        $display("FAIL dir%0d_nwrites got %0d want %0d", c, wr_log.size(), n);
      end
      for (int k = 0; k < n && k < wr_log.size(); k++) begin
        checks++;
        if (wr_log[k].addr != (lc + 1 + k) % DEPTH ||
            wr_log[k].data !== (snap[(lc + 1 + k) % DEPTH] | cmask)) begin
          failures++;
          $display("FAIL dir%0d_write%0d got a=%0d d=%0h want a=%0d d=%0h", c, k, wr_log[k].addr,
                   wr_log[k].data, (lc + 1 + k) % DEPTH, snap[(lc + 1 + k) % DEPTH] | cmask);
        end
      end
      checks++;
      if ((n == 0 && st_log.size() != 0) ||
          (n != 0 && (st_log.size() != 1 || st_log[0] !== OW'(tbl[c][5])))) begin
        failures++;
        $display("FAIL dir%0d_state_wr got n=%0d v=%0d want target %0d", c, st_log.size(),
                 (st_log.size() > 0) ? st_log[0] : 0, tbl[c][5]);
      end
      checks++;
      if (busy_cyc != ((n == 0) ? 1 : 3 * n + 2)) begin
        failures++;
        $display("FAIL dir%0d_cycles got %0d want %0d", c, busy_cyc, (n == 0) ? 1 : 3 * n + 2);
      end
      exp_ent += n;
      if (n == 0) exp_drop++;
`ifdef VR_COMMIT_WALKER_STATS_EN
      checks++;
      if (stat_entries_committed !== 32'(exp_ent) || stat_msgs_dropped !== 32'(exp_drop)) begin
        failures++;
        $display("FAIL dir%0d_stats got %0d/%0d want %0d/%0d", c, stat_entries_committed,
                 stat_msgs_dropped, exp_ent, exp_drop);
      end
`endif
    end
  endtask

  // Random messages with random backpressure; model derives the committed range from the rules.
  task automatic test_random();
    bit ok, drop;
    logic [OW-1:0] sv, mv, lc, op, mc, tgt;
    int n, errs;
    rand_rdy = 1'b1;
    for (int it = 0; it < 40; it++) begin
      sv = OW'($urandom_range(0, 3));
      mv = ($urandom_range(0, 3) != 0) ? sv : OW'($urandom_range(0, 3));
      lc = OW'($urandom_range(0, 60));
      op = lc + OW'($urandom_range(0, 30));
      mc = OW'($urandom_range(0, int'(lc) + 40));
      tgt = mc;
      if (op < tgt) tgt = op;
      if (lc + MW < tgt) tgt = lc + MW;
      drop = (mv != sv) || (tgt <= lc);
      n = drop ? 0 : int'(tgt - lc);
      do_msg(sv, lc, op, mv, mc, 1'b1, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rnd%0d_timeout engine still busy", it);
        apply_reset();
        continue;
      end
      errs = (wr_log.size() != n) ? 1 : 0;
      for (int k = 0; k < n && k < wr_log.size(); k++)
        if (wr_log[k].addr != (int'(lc) + 1 + k) % DEPTH ||
            wr_log[k].data !== (snap[(int'(lc) + 1 + k) % DEPTH] | cmask)) errs++;
      checks++;
      if (errs != 0) begin
        failures++;
        $display("FAIL rnd%0d_writes got %0d writes (%0d bad) want %0d from op %0d", it,
                 wr_log.size(), errs, n, lc + 1);
      end
      checks++;
      if ((drop && st_log.size() != 0) || (!drop && (st_log.size() != 1 || st_log[0] !== tgt))) begin
        failures++;
        $display("FAIL rnd%0d_state_wr got n=%0d v=%0d want drop=%0b target %0d", it, st_log.size(),
                 (st_log.size() > 0) ? st_log[0] : 0, drop, tgt);
      end
      exp_ent += n;
      if (drop) exp_drop++;
`ifdef VR_COMMIT_WALKER_STATS_EN
      checks++;
      if (stat_entries_committed !== 32'(exp_ent) || stat_msgs_dropped !== 32'(exp_drop)) begin
        failures++;
        $display("FAIL rnd%0d_stats got %0d/%0d want %0d/%0d", it, stat_entries_committed,
                 stat_msgs_dropped, exp_ent, exp_drop);
      end
`endif
    end
    rand_rdy = 1'b0;
  endtask

  task automatic test_stall_reset();
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    bit seen;
    rand_rdy = 1'b0;
    stall_wr = 1'b1;
    wr_log.delete();
    st_log.delete();
    state_view = 1; state_last_commit = 2; state_op_num = 10;
    @(negedge clk);
    msg_view = 1; msg_commit_num = 5; msg_val = 1'b1;
    @(negedge clk);
    msg_val = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (log_wr_val) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stall_reach_wr log_wr_val=%b want 1", log_wr_val);
    end
    a0 = log_wr_addr;
    d0 = log_wr_data;
    checks++;
    if (a0 !== AW'(3) || d0 !== (mem[3] | cmask)) begin
      failures++;
      $display("FAIL stall_first_wr got a=%0d d=%0h want a=3 d=%0h", a0, d0, mem[3] | cmask);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (log_wr_val !== 1'b1 || log_wr_addr !== a0 || log_wr_data !== d0) begin
        failures++;
        $display("FAIL stall_hold%0d got v=%b a=%0d d=%0h want v=1 a=%0d d=%0h", i, log_wr_val,
                 log_wr_addr, log_wr_data, a0, d0);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || msg_rdy !== 1'b1 || log_wr_val !== 1'b0 || state_wr_val !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset got busy=%b rdy=%b wr=%b st=%b want 0,1,0,0", busy, msg_rdy,
               log_wr_val, state_wr_val);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stall_wr = 1'b0;
    exp_ent = 0;
    exp_drop = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (st_log.size() != 0 || wr_log.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_writes got st=%0d wr=%0d busy=%b want 0,0,0", st_log.size(),
               wr_log.size(), busy);
    end
`ifdef VR_COMMIT_WALKER_STATS_EN
    checks++;
    if (stat_entries_committed !== 0 || stat_msgs_dropped !== 0) begin
      failures++;
      $display("FAIL abort_stats got %0d/%0d want 0/0", stat_entries_committed, stat_msgs_dropped);
    end
`endif
  endtask

  initial begin
    checks = 0; failures = 0; exp_ent = 0; exp_drop = 0;
    rand_rdy = 1'b0; stall_wr = 1'b0; resp_done = 1'b0; busy_cyc = 0;
    cmask = DW'(1) << CB;
    msg_val = 1'b0; msg_view = '0; msg_commit_num = '0;
    state_view = '0; state_last_commit = '0; state_op_num = '0;
    log_rd_req_rdy = 1'b1; log_rd_resp_val = 1'b0; log_rd_resp_data = '0;
    log_wr_rdy = 1'b1; state_wr_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_directed();
    test_random();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
